// File: rtl/mem_access_if.sv
// mem_access_if: data-bus handshake between the memory stage and the data memory.
//
//   dreq_valid     request valid, held until dresp_addr_ok
//   dreq_addr      byte address (word-aligned for LWL/LWR/SWL/SWR)
//   dreq_size      0=1B, 1=2B, 2=4B
//   dreq_strobe    byte write enables, all zero for reads
//   dreq_data      store data already placed on its byte lanes
//   dresp_addr_ok  request accepted
//   dresp_data_ok  read data / write completion this cycle
//   dresp_data     read data word
//
// Modports: master (mem_access side) and slave (memory side).
interface mem_access_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid,
    output dreq_addr,
    output dreq_size,
    output dreq_strobe,
    output dreq_data,
    input  dresp_addr_ok,
    input  dresp_data_ok,
    input  dresp_data
  );

  modport slave (
    input  dreq_valid,
    input  dreq_addr,
    input  dreq_size,
    input  dreq_strobe,
    input  dreq_data,
    output dresp_addr_ok,
    output dresp_data_ok,
    output dresp_data
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory-stage data-access unit.
//
// Runs the data-bus handshake for loads and stores coming out of execute, builds byte strobes
// and lane-placed store data, formats load results (sign/zero extension, LWL/LWR merge) and
// flags address-error exceptions. Holds earlier stages with o_stall while an access is in
// flight.
//
// Ports:
//   clk, rst      pipeline clock, asynchronous active-high reset
//   i_valid       instruction present in M
//   i_op          MIPS primary opcode
//   i_rm, i_wm    memory read / write requested
//   i_addr        effective address
//   i_wdata       rt value: store data or old rt for the LWL/LWR merge
//   i_kill        flush from a later stage
//   i_adv         pipeline advances M to W this cycle
//   o_stall       hold earlier stages
//   o_valid       access completed, o_rdata valid
//   o_rdata       formatted load result (0 for stores)
//   o_adel/o_ades load / store address error
//   o_badvaddr    faulting address
//   bus           data-bus master (mem_access_if.master)
//
// Build option: define MEM_UNALIGNED_LR_EN to support LWL/LWR/SWL/SWR. Without it those
// opcodes raise an address error and never reach the bus.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [5:0]   i_op,
  input  logic         i_rm,
  input  logic         i_wm,
  input  logic [31:0]  i_addr,
  input  logic [31:0]  i_wdata,
  input  logic         i_kill,
  input  logic         i_adv,
  output logic         o_stall,
  output logic         o_valid,
  output logic [31:0]  o_rdata,
  output logic         o_adel,
  output logic         o_ades,
  output logic [31:0]  o_badvaddr,
  mem_access_if.master bus
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLwl = 6'h22;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpLwr = 6'h26;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSwl = 6'h2A;
  localparam logic [5:0] OpSw  = 6'h2B;
  localparam logic [5:0] OpSwr = 6'h2E;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      r_state;
  logic        r_killed;
  logic        r_valid;
  logic [31:0] r_rdata;

  logic [1:0]  w_k;
  logic        w_half_op;
  logic        w_word_op;
  logic        w_lr_op;
  logic        w_misaln;
  logic        w_lr_fault;
  logic        w_fault;
  logic        w_mem;
  logic        w_launch;
  logic        w_kill_any;

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;

  logic [31:0] w_req_addr;
  logic [2:0]  w_req_size;
  logic [3:0]  w_req_strobe;
  logic [31:0] w_req_data;

  assign w_k = i_addr[1:0];

  // ---------------------------------------------------------------------------------------------
  // Decode and exceptions
  // ---------------------------------------------------------------------------------------------
  assign w_half_op = (i_op == OpLh) || (i_op == OpLhu) || (i_op == OpSh);
  assign w_word_op = (i_op == OpLw) || (i_op == OpSw);
  assign w_lr_op   = (i_op == OpLwl) || (i_op == OpLwr) || (i_op == OpSwl) || (i_op == OpSwr);

  assign w_misaln = (w_half_op && i_addr[0]) || (w_word_op && (w_k != 2'b00));

`ifdef MEM_UNALIGNED_LR_EN
  assign w_lr_fault = 1'b0;
`else
  // Without the unaligned-word feature these opcodes are reported as address errors.
  assign w_lr_fault = w_lr_op;
`endif

  assign w_fault    = w_misaln || w_lr_fault;
  assign w_mem      = i_valid && (i_rm || i_wm);
  assign o_adel     = w_mem && w_fault && i_rm;
  assign o_ades     = w_mem && w_fault && i_wm;
  assign o_badvaddr = i_addr;

  // Reset gates launch so the bus request drops in the same cycle reset is raised.
  assign w_launch   = w_mem && !w_fault && !i_kill && !rst;
  assign w_kill_any = r_killed || i_kill;

  // ---------------------------------------------------------------------------------------------
  // Request fields: combinational from the held M-stage inputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_req_addr   = i_addr;
    w_req_size   = 3'd2;
    w_req_strobe = 4'b0000;
    w_req_data   = i_wdata;
    unique case (i_op)
      OpLb, OpLbu: begin
        w_req_size = 3'd0;
      end
      OpSb: begin
        w_req_size   = 3'd0;
        w_req_strobe = 4'b0001 << w_k;
        w_req_data   = {24'h0, i_wdata[7:0]} << {w_k, 3'b000};
      end
      OpLh, OpLhu: begin
        w_req_size = 3'd1;
      end
      OpSh: begin
        w_req_size   = 3'd1;
        w_req_strobe = 4'b0011 << {i_addr[1], 1'b0};
        w_req_data   = {16'h0, i_wdata[15:0]} << {i_addr[1], 4'b0000};
      end
      OpSw: begin
        w_req_strobe = 4'b1111;
      end
      OpLwl, OpLwr: begin
        w_req_addr = {i_addr[31:2], 2'b00};
      end
      OpSwl: begin
        // (1 << (k+1)) - 1 == 4'b1111 >> (3-k); the high bytes of rt land at the low lanes.
        w_req_addr   = {i_addr[31:2], 2'b00};
        w_req_strobe = 4'b1111 >> (~w_k);
        w_req_data   = i_wdata >> {~w_k, 3'b000};
      end
      OpSwr: begin
        w_req_addr   = {i_addr[31:2], 2'b00};
        w_req_strobe = 4'b1111 << w_k;
        w_req_data   = i_wdata << {w_k, 3'b000};
      end
      default: begin
        // LW and anything unrecognised: full-word read.
      end
    endcase
  end

  assign bus.dreq_addr   = w_req_addr;
  assign bus.dreq_size   = w_req_size;
  assign bus.dreq_strobe = w_req_strobe;
  assign bus.dreq_data   = w_req_data;

  // ---------------------------------------------------------------------------------------------
  // Load formatting from the response word
  // ---------------------------------------------------------------------------------------------
  assign w_byte_sh = bus.dresp_data >> {w_k, 3'b000};
  assign w_half_sh = bus.dresp_data >> {i_addr[1], 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];

`ifdef MEM_UNALIGNED_LR_EN
  logic [31:0] w_lwl_mask;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;

  // rt bytes kept by LWL; none survive when k=3.
  always_comb begin
    unique case (w_k)
      2'd0:    w_lwl_mask = 32'h00FF_FFFF;
      2'd1:    w_lwl_mask = 32'h0000_FFFF;
      2'd2:    w_lwl_mask = 32'h0000_00FF;
      default: w_lwl_mask = 32'h0000_0000;
    endcase
  end

  assign w_lwl = (bus.dresp_data << {~w_k, 3'b000}) | (i_wdata & w_lwl_mask);
  assign w_lwr = (bus.dresp_data >> {w_k, 3'b000}) |
                 (i_wdata & ~(32'hFFFF_FFFF >> {w_k, 3'b000}));
`endif

  always_comb begin
    w_fmt = 32'h0;
    unique case (i_op)
      OpLb:    w_fmt = {{24{w_byte[7]}}, w_byte};
      OpLbu:   w_fmt = {24'h0, w_byte};
      OpLh:    w_fmt = {{16{w_half[15]}}, w_half};
      OpLhu:   w_fmt = {16'h0, w_half};
      OpLw:    w_fmt = bus.dresp_data;
`ifdef MEM_UNALIGNED_LR_EN
      OpLwl:   w_fmt = w_lwl;
      OpLwr:   w_fmt = w_lwr;
`endif
      default: w_fmt = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_killed <= 1'b0;
      r_valid  <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_killed <= 1'b0;
          r_valid  <= 1'b0;
          if (w_launch) begin
            if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
              r_state <= StDone;
              r_valid <= 1'b1;
              r_rdata <= w_fmt;
            end else if (bus.dresp_addr_ok) begin
              r_state <= StWait;
            end else begin
              r_state <= StReq;
            end
          end
        end
        StReq: begin
          // The request stays up through a kill; the bus must see it accepted.
          if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
            r_killed <= 1'b0;
            if (w_kill_any) begin
              r_state <= StIdle;
            end else begin
              r_state <= StDone;
              r_valid <= 1'b1;
              r_rdata <= w_fmt;
            end
          end else begin
            r_killed <= w_kill_any;
            if (bus.dresp_addr_ok) begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (bus.dresp_data_ok) begin
            r_killed <= 1'b0;
            if (w_kill_any) begin
              r_state <= StIdle;
            end else begin
              r_state <= StDone;
              r_valid <= 1'b1;
              r_rdata <= w_fmt;
            end
          end else begin
            r_killed <= w_kill_any;
          end
        end
        StDone: begin
          if (i_kill || i_adv) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // IDLE raises request and stall in the launch cycle itself; REQ and WAIT hold the pipeline
  // until the transaction drains, including killed ones.
  assign bus.dreq_valid = ((r_state == StIdle) && w_launch) || (r_state == StReq);
  assign o_stall        = ((r_state == StIdle) && w_launch) || (r_state == StReq) ||
                          (r_state == StWait);
  assign o_valid        = r_valid;
  assign o_rdata        = r_rdata;

endmodule
